// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one single-port playfield RAM among N_REQ requesters. A winner is
//   chosen in IDLE, its command is issued to the RAM for exactly one cycle
//   (ISSUE), and a read then waits RD_LAT cycles (WAIT) before returning data
//   with a one-cycle rvalid pulse. Requester HI_PRI has strict priority, limited
//   to STARVE_MAX consecutive wins while anyone else waits; the rest rotate.
//
// Ports
//   clk        system clock, all state on posedge
//   clr        asynchronous active-low reset
//   req        per-requester request, held until gnt
//   we         per-requester write flag (1 = write, 0 = read)
//   addr       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata      packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        one-hot pulse in the issue cycle
//   rvalid     one-hot pulse in the cycle rdata is valid
//   rdata      read data, meaningful only while rvalid is high
//   mem_addr   RAM address
//   mem_we     RAM write enable
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, RD_LAT cycles after the address cycle
//   busy       high in ISSUE and WAIT
module vram_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 2,
    parameter int HI_PRI     = 0,
    parameter int STARVE_MAX = 3
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam int WC_W  = $clog2(RD_LAT + 1);

    localparam logic [IDX_W-1:0] HI_IDX     = IDX_W'(HI_PRI);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(N_REQ - 1);
    localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [WC_W-1:0]  RD_LAT_C   = WC_W'(RD_LAT);
    localparam logic [N_REQ-1:0] HI_MASK    = N_REQ'(1) << HI_PRI;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [IDX_W-1:0]    r_last;
    logic [SC_W-1:0]     r_starve;
    logic [WC_W-1:0]     r_wait;

    logic [IDX_W-1:0]    r_win;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_others;
    logic                w_hi_ok;
    logic [N_REQ-1:0]    w_mask;
    logic                w_rr_found;
    logic [IDX_W-1:0]    w_rr_idx;
    logic [IDX_W-1:0]    w_win;
    logic                w_take;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    // Winner selection
    assign w_others = |(req & ~HI_MASK);
    assign w_hi_ok  = req[HI_PRI] && (r_starve < STARVE_LIM);
    assign w_take   = (r_state == S_IDLE) && (|req);

    // When the starve limit blocks HI_PRI it must also stay out of the
    // rotation, otherwise it could still win by position.
    always_comb begin
        w_mask = req;
        if (!w_hi_ok && w_others)
            w_mask = req & ~HI_MASK;
    end

    // Round-robin: first requester above last_gnt, else wrap to the lowest.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_rr_found && w_mask[i] && (i > int'(r_last))) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_rr_found && w_mask[i] && (i <= int'(r_last))) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDX_W'(i);
            end
        end
    end

    assign w_win = w_hi_ok ? HI_IDX : w_rr_idx;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_sel_we    = we[i];
                w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|req) w_next = S_ISSUE;
            S_ISSUE: w_next = r_we ? S_IDLE : S_WAIT;
            S_WAIT:  if (r_wait == RD_LAT_C) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Arbitration history and read latency counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_last   <= LAST_RST;
            r_starve <= '0;
            r_wait   <= '0;
        end else begin
            if (w_take) begin
                r_last <= w_win;
                if (w_win == HI_IDX && w_others) begin
                    if (r_starve != STARVE_LIM)
                        r_starve <= r_starve + SC_W'(1);
                end else begin
                    r_starve <= '0;
                end
            end
            if (r_state == S_ISSUE)
                r_wait <= WC_W'(1);
            else if (r_state == S_WAIT && r_wait != RD_LAT_C)
                r_wait <= r_wait + WC_W'(1);
        end
    end

    // Captured command; only observed outside IDLE, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_win   <= w_win;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    // Outputs decode from state so reset clears them immediately
    always_comb begin
        gnt       = '0;
        rvalid    = '0;
        rdata     = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        case (r_state)
            S_ISSUE: begin
                busy      = 1'b1;
                gnt       = N_REQ'(1) << r_win;
                mem_addr  = r_addr;
                mem_we    = r_we;
                mem_wdata = r_wdata;
            end
            S_WAIT: begin
                busy     = 1'b1;
                mem_addr = r_addr;
                if (r_wait == RD_LAT_C) begin
                    rvalid = N_REQ'(1) << r_win;
                    rdata  = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            clr;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            busy;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    vram_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .HI_PRI(0), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with two-cycle read latency from the address cycle
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        rd_p1 <= ram[mem_addr];
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = rd_p2;

    typedef struct {
        int          idx;
        logic        wr;
        logic [9:0]  a;
        logic [7:0]  d;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fill_lanes();
        for (int i = 0; i < N; i++) begin
            addr[i*AW +: AW]  = AW'(i*73 + 17);
            wdata[i*DW +: DW] = DW'(i*29 + 3);
        end
    endtask

    // Starts and ends just after a posedge with the DUT idle
    task automatic do_txn(input vec_t v);
        req = '0; we = '0;
        fill_lanes();
        addr[v.idx*AW +: AW]  = v.a;
        wdata[v.idx*DW +: DW] = v.d;
        req[v.idx] = 1'b1;
        we[v.idx]  = v.wr;
        @(posedge clk); #1;
        // Captured now: later changes must not leak through
        req = '0;
        addr[v.idx*AW +: AW]  = ~v.a;
        wdata[v.idx*DW +: DW] = ~v.d;
        @(negedge clk);
        check("txn_gnt", int'(gnt), 1 << v.idx);
        check("txn_mem_we", int'(mem_we), int'(v.wr));
        check("txn_mem_addr", int'(mem_addr), int'(v.a));
        check("txn_rvalid_at_gnt", int'(rvalid), 0);
        if (v.wr) begin
            check("txn_mem_wdata", int'(mem_wdata), int'(v.d));
            @(negedge clk);
            check("txn_wr_done_busy", int'(busy), 0);
            check("txn_idle_addr_data", int'({mem_addr, mem_wdata}), 0);
        end else begin
            @(negedge clk);
            check("txn_wait_rvalid", int'(rvalid), 0);
            check("txn_wait_addr_we", int'({mem_addr, mem_we}), int'({v.a, 1'b0}));
            @(negedge clk);
            check("txn_rvalid", int'(rvalid), 1 << v.idx);
            check("txn_rdata", int'(rdata), int'(v.exp_rd));
            @(negedge clk);
            check("txn_rd_done", int'({busy, rvalid}), 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_gnt(output int idx, output int at);
        idx = -1;
        at  = 0;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            if (gnt != '0) begin
                at = cyc;
                for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
                check("gnt_onehot", int'($onehot(gnt)), 1);
                check("gnt_rvalid_overlap", int'(rvalid), 0);
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr [6];
        int exp_pr [8];
        int idx, at, prev;

        vecs[0] = '{2, 1'b1, 10'h155, 8'h3C, 8'h00};
        vecs[1] = '{1, 1'b1, 10'h020, 8'hA5, 8'h00};
        vecs[2] = '{1, 1'b0, 10'h020, 8'h00, 8'hA5};
        vecs[3] = '{3, 1'b1, 10'h3FF, 8'h81, 8'h00};
        vecs[4] = '{0, 1'b0, 10'h155, 8'h00, 8'h3C};
        vecs[5] = '{3, 1'b0, 10'h3FF, 8'h00, 8'h81};
        vecs[6] = '{2, 1'b0, 10'h020, 8'h00, 8'hA5};
        exp_rr = '{1, 2, 3, 1, 2, 3};
        exp_pr = '{0, 0, 0, 3, 0, 0, 0, 3};

        clr = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        #1;
        check("reset_outputs", int'({gnt, rvalid, busy, mem_we, mem_addr, mem_wdata}), 0);
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_quiet", int'({gnt, busy, mem_we}), 0);
        end
        @(posedge clk); #1;

        foreach (vecs[k]) do_txn(vecs[k]);

        // Reset during WAIT of a read
        fill_lanes();
        addr[1*AW +: AW] = 10'h020;
        req = 4'b0010; we = 4'b0000;
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #2;
        clr = 1'b0;
        #1;
        check("midread_reset_outputs", int'({gnt, rvalid, busy, mem_we, mem_addr}), 0);
        @(posedge clk); #1;
        clr = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("after_reset_no_rvalid", int'({rvalid, busy}), 0);
        end
        @(posedge clk); #1;

        // Round-robin among 1..3, reads
        fill_lanes();
        we = 4'b0000; req = 4'b1110;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            wait_gnt(idx, at);
            check("rr_order", idx, exp_rr[k]);
            if (k > 0) check("rr_gap", at - prev, 4);
            prev = at;
        end
        req = '0;
        repeat (8) @(negedge clk);
        check("rr_drain", int'(busy), 0);
        @(posedge clk); #1;

        // Requester 0 alone, re-raising req the cycle after each gnt
        we = 4'b0001; req = 4'b0001;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(idx, at);
            check("rereq_order", idx, 0);
            if (k > 0) check("rereq_gap", at - prev, 2);
            prev = at;
            req = '0;
            @(posedge clk); #1;
            req = 4'b0001;
        end

        // HI_PRI against requester 3; starve count must start from zero
        we = 4'b1001; req = 4'b1001;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            wait_gnt(idx, at);
            check("prio_order", idx, exp_pr[k]);
            if (k > 0) check("prio_gap", at - prev, 2);
            prev = at;
        end
        req = '0;
        repeat (4) @(negedge clk);
        check("prio_drain", int'({busy, gnt}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Arbiter and sequencer that shares one single-port playfield RAM among N_REQ requesters. Typical requesters are the display renderer, mushroom-field updates, the centipede engine and shot collision. It captures one request, drives the RAM port for one cycle, and returns read data with a per-requester valid pulse. The display requester (HI_PRI) has strict priority, bounded by an anti-starvation counter; all others are served round-robin.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 10, RAM address width
DATA_W, 8, RAM data width
RD_LAT, 2, RAM read latency in cycles from the address cycle to valid mem_rdata (1..3)
HI_PRI, 0, index of the strict-priority requester
STARVE_MAX, 3, consecutive HI_PRI wins allowed while another requester waits

Ports:
clk  input  1  system clock, all state on posedge
clr  input  1  asynchronous active-low reset
req  input  N_REQ  request per requester; held until gnt
we  input  N_REQ  1 = write, 0 = read, per requester
addr  input  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
wdata  input  N_REQ*DATA_W  packed write data, same packing
gnt  output  N_REQ  one-hot, one-cycle pulse marking the issue cycle
rvalid  output  N_REQ  one-hot, one-cycle pulse when rdata is valid for that requester
rdata  output  DATA_W  read data; valid only when rvalid is high
mem_addr  output  ADDR_W  RAM address
mem_we  output  1  RAM write enable
mem_wdata  output  DATA_W  RAM write data
mem_rdata  input  DATA_W  RAM read data
busy  output  1  high in ISSUE and WAIT states

Behaviour:
- Reset (clr low, asynchronous):
  - state=IDLE, last_gnt=N_REQ-1, starve_cnt=0, wait_cnt=0.
  - All outputs 0 immediately.
  - An in-flight read is discarded; no rvalid is produced for it.
- States:
  - IDLE: if req is nonzero, pick a winner, capture its index, we, addr and wdata into registers, and go to ISSUE. Otherwise stay.
  - ISSUE: one cycle.
    - gnt[winner]=1; mem_addr/mem_we/mem_wdata driven from the captured registers.
    - mem_we=1 only for a write.
    - Write: go to IDLE next. Read: go to WAIT with wait_cnt=1.
  - WAIT: increments wait_cnt each cycle.
    - When wait_cnt==RD_LAT: rdata<=mem_rdata and rvalid[winner]=1 in that same cycle, then go to IDLE.
    - mem_we=0 throughout; mem_addr holds the captured address.
- Timing (IDLE sample at cycle N):
  - gnt at N+1.
  - Write completes at N+1; next arbitration at N+2.
  - Read: rvalid at N+1+RD_LAT; next arbitration at N+2+RD_LAT.
- Winner selection, evaluated in IDLE only:
  - a) If req[HI_PRI]=1 and starve_cnt<STARVE_MAX, the winner is HI_PRI.
  - b) Otherwise, the winner is the first requesting index scanning last_gnt+1, last_gnt+2, … modulo N_REQ. HI_PRI is excluded from this scan when it was skipped by the starve rule and any other requester is active.
  - last_gnt updates to the winner on every grant, including HI_PRI grants.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) when HI_PRI wins while any other req bit is high.
  - Reset to 0 when a non-HI_PRI requester wins, or when HI_PRI wins with no other req.
- Requester protocol:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Dropping req after the IDLE capture cycle does not cancel the transaction.
  - A requester may re-raise req immediately after gnt. It competes normally at the next IDLE.
- Packed port inputs are sampled only in IDLE; changes during ISSUE/WAIT are ignored.
- At most one gnt bit and one rvalid bit are high in any cycle. gnt and rvalid never coincide.
- mem_addr and mem_wdata are 0 in IDLE.

Test Plan:
- Reset/idle: clr low mid-read (RD_LAT=2, during WAIT) -> all outputs 0 at once; after release, no rvalid and state IDLE; req=0000 for 10 cycles -> gnt, busy and mem_we stay 0.
- Single write: req[2]=1, we[2]=1, addr2=0x155, wdata2=0x3C sampled at cycle N -> gnt=0100 and mem_we=1, mem_addr=0x155, mem_wdata=0x3C at N+1; busy=0 at N+2.
- Single read: req[1] read addr=0x020 with RAM holding 0xA5 -> gnt=0010 at N+1, rvalid=0010 and rdata=0xA5 at N+3, no other rvalid.
- Round-robin: req[1], req[2] and req[3] held high with reads, HI_PRI idle -> grant order 1, 2, 3, 1, 2, 3; each grant separated by RD_LAT+2=4 cycles.
- Priority plus starvation: req[0] and req[3] held high, writes -> grant order 0, 0, 0, 3, 0, 0, 0, 3 (STARVE_MAX=3).
- Re-request: requester 0 alone, raises req again the cycle after gnt -> granted every 2 cycles (writes), starve_cnt stays 0.
